// File: rtl/maze_game_ctrl.sv
// Purpose : game-flow controller between the keycode source and the ball stage.
//           It gates player keycodes, opens the gate when the key is picked up,
//           runs the round timer and declares a win or a loss.
// Latency : all outputs are registered and change one frame_clk edge after
//           their cause. keycode_out lags keycode_in by one frame.
// Flow    : there is no backpressure. The block advances once per frame tick.
// Ports   : frame_clk, Reset (async, active-high), keycode_in[7:0],
//           BallX[9:0], BallY[9:0] -> keycode_out[7:0], ended, ball_reset,
//           won, lost, seconds_left[6:0], game_state[1:0] (00 IDLE,
//           01 PLAY, 10 WON, 11 LOST).
module maze_game_ctrl #(
  parameter logic [7:0] START_KEY      = 8'h2C,
  parameter int         KEY_X_MIN      = 600,
  parameter int         KEY_X_MAX      = 620,
  parameter int         KEY_Y_MIN      = 440,
  parameter int         KEY_Y_MAX      = 460,
  parameter int         GATE_X1        = 277,
  parameter int         GATE_X2        = 300,
  parameter int         EXIT_Y         = 8,
  parameter int         FRAMES_PER_SEC = 60,
  parameter int         TIME_LIMIT     = 99
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  output logic [7:0] keycode_out,
  output logic       ended,
  output logic       ball_reset,
  output logic       won,
  output logic       lost,
  output logic [6:0] seconds_left,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WON  = 2'b10,
    ST_LOST = 2'b11
  } state_t;

  localparam logic [9:0] KX_LO    = 10'(KEY_X_MIN);
  localparam logic [9:0] KX_HI    = 10'(KEY_X_MAX);
  localparam logic [9:0] KY_LO    = 10'(KEY_Y_MIN);
  localparam logic [9:0] KY_HI    = 10'(KEY_Y_MAX);
  localparam logic [9:0] GX_LO    = 10'(GATE_X1);
  localparam logic [9:0] GX_HI    = 10'(GATE_X2);
  localparam logic [9:0] EXIT_LIM = 10'(EXIT_Y);
  localparam logic [5:0] FPS_LAST = 6'(FRAMES_PER_SEC - 1);
  localparam logic [6:0] TL       = 7'(TIME_LIMIT);

  state_t     state_q, state_d;
  logic [5:0] frame_cnt, frame_cnt_d;
  logic [7:0] prev_key;
  logic [7:0] keycode_d;
  logic [6:0] sec_d;
  logic       ended_d, won_d, lost_d, ball_reset_d;

  logic start_edge;
  logic in_key_box;
  logic win_hit;
  logic sec_tick;

  // A held start key is seen only on its first frame.
  assign start_edge = (keycode_in == START_KEY) && (prev_key != START_KEY);

  assign in_key_box = (BallX >= KX_LO) && (BallX <= KX_HI) &&
                      (BallY >= KY_LO) && (BallY <= KY_HI);

  // Uses the registered ended: a pickup and an escape on the same frame is
  // not a win.
  assign win_hit = ended && (BallY <= EXIT_LIM) &&
                   (BallX >= GX_LO) && (BallX <= GX_HI);

  assign sec_tick = (frame_cnt == FPS_LAST);

  assign game_state = state_q;

  // Only keys pressed while in play reach the ball. This means the entry
  // frame forwards 0 and the exit frame still forwards the last key.
  assign keycode_d = (state_q == ST_PLAY) ? keycode_in : 8'h00;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt;
    sec_d        = seconds_left;
    ended_d      = ended;
    won_d        = won;
    lost_d       = lost;
    ball_reset_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        frame_cnt_d = 6'd0;
        sec_d       = TL;
        ended_d     = 1'b0;
        won_d       = 1'b0;
        lost_d      = 1'b0;
        if (start_edge) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (sec_tick) begin
          frame_cnt_d = 6'd0;
          sec_d       = seconds_left - 7'd1;
        end else begin
          frame_cnt_d = frame_cnt + 6'd1;
        end

        if (in_key_box) begin
          ended_d = 1'b1;
        end

        // Escape beats a timeout on the same frame. The timer still counts
        // down on that frame.
        if (win_hit) begin
          state_d = ST_WON;
          won_d   = 1'b1;
        end else if (sec_tick && (seconds_left == 7'd1)) begin
          state_d = ST_LOST;
          lost_d  = 1'b1;
        end
      end

      ST_WON, ST_LOST: begin
        if (start_edge) begin
          state_d      = ST_IDLE;
          frame_cnt_d  = 6'd0;
          sec_d        = TL;
          ended_d      = 1'b0;
          won_d        = 1'b0;
          lost_d       = 1'b0;
          ball_reset_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      frame_cnt    <= 6'd0;
      prev_key     <= 8'h00;
      keycode_out  <= 8'h00;
      seconds_left <= TL;
      ended        <= 1'b0;
      won          <= 1'b0;
      lost         <= 1'b0;
      ball_reset   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt    <= frame_cnt_d;
      prev_key     <= keycode_in;
      keycode_out  <= keycode_d;
      seconds_left <= sec_d;
      ended        <= ended_d;
      won          <= won_d;
      lost         <= lost_d;
      ball_reset   <= ball_reset_d;
    end
  end

endmodule

// File: tb/tb_maze_game_ctrl.sv
module tb_maze_game_ctrl;

  localparam int F_ST   = 0;
  localparam int F_KC   = 1;
  localparam int F_END  = 2;
  localparam int F_BR   = 3;
  localparam int F_WON  = 4;
  localparam int F_LOST = 5;
  localparam int F_SEC  = 6;
  localparam int S_ST   = 7;
  localparam int S_SEC  = 8;
  localparam int S_WON  = 9;
  localparam int S_LOST = 10;
  localparam int S_BR   = 11;
  localparam int S_END  = 12;

  typedef struct {
    string tag;
    int    fld;
    int    val;
  } exp_t;

  logic       frame_clk = 1'b0;
  logic       Reset;

  logic [7:0] kc, kc_s;
  logic [9:0] bx, by, bx_s, by_s;

  logic [7:0] kco, kco_s;
  logic       ended, ended_s, br, br_s, won, won_s, lost, lost_s;
  logic [6:0] sec, sec_s;
  logic [1:0] st, st_s;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 frame_clk = ~frame_clk;

  maze_game_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode_in  (kc),
    .BallX       (bx),
    .BallY       (by),
    .keycode_out (kco),
    .ended       (ended),
    .ball_reset  (br),
    .won         (won),
    .lost        (lost),
    .seconds_left(sec),
    .game_state  (st)
  );

  maze_game_ctrl #(.FRAMES_PER_SEC(3), .TIME_LIMIT(2)) dut_s (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode_in  (kc_s),
    .BallX       (bx_s),
    .BallY       (by_s),
    .keycode_out (kco_s),
    .ended       (ended_s),
    .ball_reset  (br_s),
    .won         (won_s),
    .lost        (lost_s),
    .seconds_left(sec_s),
    .game_state  (st_s)
  );

  function automatic int obs(int f);
    case (f)
      F_ST:    return int'(st);
      F_KC:    return int'(kco);
      F_END:   return int'(ended);
      F_BR:    return int'(br);
      F_WON:   return int'(won);
      F_LOST:  return int'(lost);
      F_SEC:   return int'(sec);
      S_ST:    return int'(st_s);
      S_SEC:   return int'(sec_s);
      S_WON:   return int'(won_s);
      S_LOST:  return int'(lost_s);
      S_BR:    return int'(br_s);
      S_END:   return int'(ended_s);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic ex(input string tag, input int f, input int v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // One frame: clock edge, then compare everything queued for this frame.
  task automatic tick();
    exp_t e;
    @(posedge frame_clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, obs(e.fld), e.val);
    end
  endtask

  initial begin
    Reset = 1'b1;
    kc = 8'h00; bx = 10'd340; by = 10'd240;
    kc_s = 8'h00; bx_s = 10'd340; by_s = 10'd240;
    repeat (2) @(posedge frame_clk);
    #1;
    chk("rst_state", int'(st), 0);
    chk("rst_kc", int'(kco), 0);
    chk("rst_sec", int'(sec), 99);
    chk("rst_flags", int'({ended, won, lost, br}), 0);
    Reset = 1'b0;

    // Keys are not forwarded in IDLE.
    kc = 8'h04;
    ex("idle_kc", F_KC, 0); ex("idle_st", F_ST, 0); tick();

    // Start: PLAY on the same edge, keycode_out still 0 there.
    kc = 8'h2C;
    ex("start_st", F_ST, 1); ex("entry_kc", F_KC, 0); ex("entry_sec", F_SEC, 99); tick();
    kc = 8'h04;
    ex("fwd_kc", F_KC, 4); ex("fwd_st", F_ST, 1); tick();

    // Held/repressed start key in PLAY is ignored.
    for (int i = 0; i < 10; i++) begin
      kc = 8'h2C;
      ex("hold_st", F_ST, 1); ex("hold_kc", F_KC, 8'h2C); tick();
    end
    // 11 PLAY frames so far; 49 more make the first second elapse.
    for (int i = 1; i <= 49; i++) begin
      kc = 8'h1A;
      ex("run_st", F_ST, 1);
      if (i == 48) ex("sec_before", F_SEC, 99);
      if (i == 49) ex("sec_after", F_SEC, 98);
      tick();
    end

    // Gate without the key: no win.
    bx = 10'd290; by = 10'd5;
    ex("nokey_st", F_ST, 1); ex("nokey_end", F_END, 0); tick();
    // Key pickup.
    bx = 10'd610; by = 10'd450;
    ex("pick_end", F_END, 1); ex("pick_st", F_ST, 1); tick();
    bx = 10'd340; by = 10'd240;
    ex("sticky_end", F_END, 1); tick();
    // One pixel right of the gate.
    bx = 10'd301; by = 10'd5;
    ex("gate_edge_st", F_ST, 1); tick();
    // Escape.
    bx = 10'd290; by = 10'd5;
    ex("win_st", F_ST, 2); ex("win_won", F_WON, 1); ex("exit_kc", F_KC, 8'h1A); tick();
    bx = 10'd340; by = 10'd240;
    ex("won_kc", F_KC, 0); ex("won_hold", F_WON, 1); ex("won_sec", F_SEC, 98);
    ex("won_end", F_END, 1); ex("won_lost", F_LOST, 0); tick();

    // Restart from WON.
    kc = 8'h2C;
    ex("rs_st", F_ST, 0); ex("rs_br", F_BR, 1); ex("rs_end", F_END, 0);
    ex("rs_won", F_WON, 0); ex("rs_sec", F_SEC, 99); tick();
    ex("rs_br_off", F_BR, 0); ex("rs_held", F_ST, 0); tick();

    // Short timer instance: 3 frames/s, 2 s.
    kc_s = 8'h2C;
    ex("s_start", S_ST, 1); ex("s_sec0", S_SEC, 2); tick();
    kc_s = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) ex("s_sec1", S_SEC, 1);
      if (i == 5) ex("s_play5", S_ST, 1);
      if (i == 6) begin
        ex("s_lost_st", S_ST, 3); ex("s_lost", S_LOST, 1); ex("s_lost_sec", S_SEC, 0);
      end
      tick();
    end
    ex("s_lost_hold", S_ST, 3); ex("s_sec_frozen", S_SEC, 0); tick();
    kc_s = 8'h2C;
    ex("s_rs_st", S_ST, 0); ex("s_rs_lost", S_LOST, 0); ex("s_rs_sec", S_SEC, 2);
    ex("s_rs_br", S_BR, 1); tick();
    kc_s = 8'h00;
    ex("s_br_off", S_BR, 0); tick();
    kc_s = 8'h2C;
    ex("s_start2", S_ST, 1); tick();
    kc_s = 8'h00;
    // Win on the same edge as the timeout.
    for (int i = 1; i <= 6; i++) begin
      if (i == 1) begin
        bx_s = 10'd610; by_s = 10'd450;
        ex("s_pick", S_END, 1);
      end else if (i == 6) begin
        bx_s = 10'd290; by_s = 10'd5;
        ex("s_tie_st", S_ST, 2); ex("s_tie_won", S_WON, 1);
        ex("s_tie_lost", S_LOST, 0); ex("s_tie_sec", S_SEC, 0);
      end else begin
        bx_s = 10'd340; by_s = 10'd240;
        if (i == 5) ex("s_pre_tie", S_ST, 1);
      end
      tick();
    end

    // Async reset in the middle of a PLAY round.
    kc = 8'h1A; tick();
    kc = 8'h2C;
    ex("r2_start", F_ST, 1); tick();
    kc = 8'h04;
    bx = 10'd610; by = 10'd450;
    ex("r2_end", F_END, 1); ex("r2_kc", F_KC, 4); tick();
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_st", int'(st), 0);
    chk("arst_kc", int'(kco), 0);
    chk("arst_end", int'(ended), 0);
    chk("arst_sec", int'(sec), 99);
    chk("arst_br", int'(br), 0);
    chk("arst_s_won", int'(won_s), 0);
    @(posedge frame_clk);
    #1;
    chk("arst_br_hold", int'(br), 0);
    Reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
